iir_rr_sched: RTL and testbench

Round-robin scheduler that time-shares one first-order IIR datapath, y(n) = 0.75·x(n) + 0.25·y(n-1), among CH independent sample streams. The block arbitrates the requesters and keeps a per-channel y(n-1) history. It also sequences a multi-cycle history-clear sweep and presents one filtered sample per cycle through a valid/ready output port. It sits between the sample sources and downstream consumers, replacing CH separate filter instances.

---
 rtl/iir_rr_sched.sv | 130 +++++++++++++
 tb/tb_iir_rr_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iir_rr_sched.sv
// iir_rr_sched: round-robin scheduler sharing one first-order IIR datapath
// y = (3*x + y_prev) >> 2 across CH sample streams, with a per-channel
// history, a CH-cycle history-clear sweep and a registered valid/ready output.
module iir_rr_sched #(
    parameter int CH  = 4,
    parameter int CHW = 2,
    parameter int DW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    req,
    input  logic [CH*DW-1:0] i_data,
    output logic [CH-1:0]    ack,
    input  logic             clr,
    output logic             busy,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CHW-1:0]   o_ch,
    output logic [DW-1:0]    o_y
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t           state_q;
    logic [CHW-1:0]   cnt_q;
    logic [CHW-1:0]   rr_q;
    logic             o_valid_q;
    logic [CHW-1:0]   o_ch_q;
    logic [DW-1:0]    o_y_q;
    logic [DW-1:0]    hist_q [CH];

    logic [CH-1:0]    ack_d;
    logic [CHW-1:0]   gnt_ch;
    logic             xfer;
    logic [DW-1:0]    x_sel;
    logic [DW-1:0]    h_sel;
    logic [DW+1:0]    sum;
    logic [DW-1:0]    y_d;
    logic [CHW-1:0]   rr_d;

    // Round-robin search starting at rr; only in RUN and when the output slot frees up
    always_comb begin
        int             idx;
        logic [CHW-1:0] cand;
        ack_d  = '0;
        gnt_ch = '0;
        xfer   = 1'b0;
        idx    = 0;
        cand   = '0;
        if (state_q == ST_RUN && (!o_valid_q || o_ready)) begin
            for (int i = 0; i < CH; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= CH) idx = idx - CH;
                cand = CHW'(idx);
                if (!xfer && req[cand]) begin
                    xfer   = 1'b1;
                    gnt_ch = cand;
                end
            end
        end
        if (xfer) ack_d[gnt_ch] = 1'b1;
    end

    // Filter datapath: mux the granted sample/history, 3x + h at DW+2 bits, then >>2
    always_comb begin
        x_sel = '0;
        for (int c = 0; c < CH; c++) begin
            if (gnt_ch == CHW'(c)) x_sel = i_data[c*DW +: DW];
        end
        h_sel = hist_q[gnt_ch];
        sum   = {2'b00, x_sel} + {1'b0, x_sel, 1'b0} + {2'b00, h_sel};
        y_d   = DW'(sum >> 2);
        rr_d  = (gnt_ch == CHW'(CH-1)) ? '0 : gnt_ch + 1'b1;
    end

    // Control FSM, arbitration pointer and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            rr_q      <= '0;
            o_valid_q <= 1'b0;
            o_ch_q    <= '0;
            o_y_q     <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CHW'(CH-1)) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (clr) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
            endcase
            if (xfer) begin
                rr_q      <= rr_d;
                o_valid_q <= 1'b1;
                o_ch_q    <= gnt_ch;
                o_y_q     <= y_d;
            end else if (o_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    // History RAM: sweep writes zero, otherwise the granted channel takes y
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            hist_q[cnt_q] <= '0;
        end else if (xfer) begin
            hist_q[gnt_ch] <= y_d;
        end
    end

    assign ack     = ack_d;
    assign busy    = (state_q == ST_CLEAR);
    assign o_valid = o_valid_q;
    assign o_ch    = o_ch_q;
    assign o_y     = o_y_q;

endmodule

// File: tb/tb_iir_rr_sched.sv
// Directed bench for iir_rr_sched: vector table plus clear-restart and
// asynchronous-reset sequences. Inputs change 1ns after posedge, checks at negedge.
module tb_iir_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] i_data;
    logic [3:0]  ack;
    logic        clr;
    logic        busy;
    logic        o_valid;
    logic        o_ready;
    logic [1:0]  o_ch;
    logic [7:0]  o_y;

    int checks = 0;
    int errors = 0;

    iir_rr_sched #(.CH(4), .CHW(2), .DW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .i_data(i_data), .ack(ack),
        .clr(clr), .busy(busy), .o_valid(o_valid), .o_ready(o_ready),
        .o_ch(o_ch), .o_y(o_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        rdy;
        logic        clr;
        logic [3:0]  e_ack;
        logic        e_busy;
        logic        e_vld;
        logic [1:0]  e_ch;
        logic [7:0]  e_y;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic add(input logic [3:0] r, input logic [31:0] d, input logic rd, input logic c,
                       input logic [3:0] ea, input logic eb, input logic ev,
                       input int ech, input int ey);
        vec_t v;
        v.req = r; v.data = d; v.rdy = rd; v.clr = c;
        v.e_ack = ea; v.e_busy = eb; v.e_vld = ev; v.e_ch = 2'(ech); v.e_y = 8'(ey);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d1, d2, d3, d4;
        int n;
        d1 = pk(200, 100, 40, 8);
        d2 = pk(200, 100, 40, 255);
        d3 = pk(200, 100, 40, 0);
        d4 = pk(4, 100, 4, 0);

        // clear sweep after reset
        for (int i = 0; i < 4; i++) add(4'hf, d1, 1, 0, 4'h0, 1, 0, 0, 0);
        // single channel 0, x=200
        add(4'h1, d1, 1, 0, 4'h1, 0, 0, 0, 0);
        add(4'h1, d1, 1, 0, 4'h1, 0, 1, 0, 150);
        add(4'h1, d1, 1, 0, 4'h1, 0, 1, 0, 187);
        add(4'h1, d1, 1, 0, 4'h1, 0, 1, 0, 196);
        add(4'h0, d1, 1, 0, 4'h0, 0, 1, 0, 199);
        // all requesting, rr starts at 1
        add(4'hf, d1, 1, 0, 4'h2, 0, 0, 0, 0);
        add(4'hf, d1, 1, 0, 4'h4, 0, 1, 1, 75);
        add(4'hf, d1, 1, 0, 4'h8, 0, 1, 2, 30);
        add(4'hf, d1, 1, 0, 4'h1, 0, 1, 3, 6);
        add(4'hf, d1, 1, 0, 4'h2, 0, 1, 0, 199);
        // backpressure for 3 cycles, grant as soon as ready rises
        add(4'hf, d1, 0, 0, 4'h0, 0, 1, 1, 93);
        add(4'hf, d1, 0, 0, 4'h0, 0, 1, 1, 93);
        add(4'hf, d1, 0, 0, 4'h0, 0, 1, 1, 93);
        add(4'hf, d1, 1, 0, 4'h4, 0, 1, 1, 93);
        // full-scale input on channel 3: no wrap, settles at 254
        add(4'h8, d2, 1, 0, 4'h8, 0, 1, 2, 37);
        add(4'h8, d2, 1, 0, 4'h8, 0, 1, 3, 192);
        add(4'h8, d2, 1, 0, 4'h8, 0, 1, 3, 239);
        add(4'h8, d2, 1, 0, 4'h8, 0, 1, 3, 251);
        add(4'h8, d2, 1, 0, 4'h8, 0, 1, 3, 254);
        // then zero input decays
        add(4'h8, d3, 1, 0, 4'h8, 0, 1, 3, 254);
        add(4'h8, d3, 1, 0, 4'h8, 0, 1, 3, 63);
        add(4'h8, d3, 1, 0, 4'h8, 0, 1, 3, 15);
        add(4'h8, d3, 1, 0, 4'h8, 0, 1, 3, 3);
        add(4'h0, d3, 1, 0, 4'h0, 0, 1, 3, 0);
        // clr coincident with a transfer: result still delivered
        add(4'h1, d1, 1, 1, 4'h1, 0, 0, 0, 0);
        add(4'h1, d1, 1, 0, 4'h0, 1, 1, 0, 199);
        add(4'h1, d1, 1, 0, 4'h0, 1, 0, 0, 0);
        add(4'h1, d1, 1, 0, 4'h0, 1, 0, 0, 0);
        add(4'h1, d1, 1, 0, 4'h0, 1, 0, 0, 0);
        // history zeroed: x=4 -> 3
        add(4'h1, d4, 1, 0, 4'h1, 0, 0, 0, 0);
        add(4'h0, d4, 1, 0, 4'h0, 0, 1, 0, 3);

        rst = 1'b1; req = '0; i_data = '0; clr = 1'b0; o_ready = 1'b1;
        @(negedge clk);
        chk("reset busy", 32'(busy), 1);
        chk("reset o_valid", 32'(o_valid), 0);
        chk("reset o_ch", 32'(o_ch), 0);
        chk("reset o_y", 32'(o_y), 0);
        chk("reset ack", 32'(ack), 0);
        next_cycle();
        rst = 1'b0;

        foreach (vq[i]) begin
            req = vq[i].req; i_data = vq[i].data; o_ready = vq[i].rdy; clr = vq[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d ack", i), 32'(ack), 32'(vq[i].e_ack));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
            chk($sformatf("v%0d o_valid", i), 32'(o_valid), 32'(vq[i].e_vld));
            if (vq[i].e_vld) begin
                chk($sformatf("v%0d o_ch", i), 32'(o_ch), 32'(vq[i].e_ch));
                chk($sformatf("v%0d o_y", i), 32'(o_y), 32'(vq[i].e_y));
            end
            next_cycle();
        end

        // clr during the sweep restarts the count
        req = 4'h0; clr = 1'b1; o_ready = 1'b1; i_data = d4;
        @(negedge clk);
        chk("restart c0 busy", 32'(busy), 0);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            req = 4'hf; clr = (c == 2);
            @(negedge clk);
            chk($sformatf("restart c%0d busy", c), 32'(busy), 1);
            chk($sformatf("restart c%0d ack", c), 32'(ack), 0);
        end
        next_cycle();
        req = 4'h4; clr = 1'b0;
        @(negedge clk);
        chk("restart c7 busy", 32'(busy), 0);
        chk("restart c7 ack", 32'(ack), 32'h4);
        next_cycle();
        req = 4'h2;
        @(negedge clk);
        chk("restart ch2 o_ch", 32'(o_ch), 2);
        chk("restart ch2 o_y", 32'(o_y), 3);
        chk("pre-reset ack", 32'(ack), 32'h2);

        // async reset in the middle of a transfer cycle
        #2 rst = 1'b1;
        #1;
        chk("async rst o_valid", 32'(o_valid), 0);
        chk("async rst busy", 32'(busy), 1);
        chk("async rst ack", 32'(ack), 0);
        next_cycle();
        rst = 1'b0;
        req = 4'hf;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("post-reset sweep len", 32'(n), 4);
        chk("post-reset rr ack", 32'(ack), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("post-reset ch0 o_y", 32'(o_y), 3);
        chk("post-reset next ack", 32'(ack), 32'h2);
        next_cycle();
        req = 4'h0;
        @(negedge clk);
        chk("post-reset ch1 o_ch", 32'(o_ch), 1);
        chk("post-reset ch1 o_y", 32'(o_y), 75);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
